// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for an RV32I core: captures one decoded instruction,
// generates ALU control, selects forwarded operands and detects load-use hazards.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [6:0]  id_opcode,
  input  logic [2:0]  id_funct3,
  input  logic        id_funct7_5,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  exm_rd,
  input  logic        exm_we,
  input  logic [31:0] exm_result,
  input  logic [4:0]  mwb_rd,
  input  logic        mwb_we,
  input  logic [31:0] mwb_result,
  output logic [31:0] alu_d1,
  output logic [31:0] alu_d2,
  output logic [3:0]  alu_control,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_is_branch,
  output logic        ex_illegal,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_store_data,
  output logic [2:0]  ex_funct3,
  output logic        load_use_stall
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Encodings chosen so the all-zero reset/bubble state selects rs1/rs2 of x0.
  typedef enum logic [1:0] {D1_RS1, D1_PC, D1_ZERO} d1_sel_e;
  typedef enum logic [1:0] {D2_RS2, D2_IMM, D2_FOUR} d2_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_control;
    d1_sel_e     d1_sel;
    d2_sel_e     d2_sel;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        illegal;
  } ex_t;

  ex_t        ex_q, ex_d, dec;
  logic [3:0] ctrl_raw;
  logic       writes;
  logic       uses_rs1, uses_rs2;
  logic [31:0] rs1_fwd, rs2_fwd;

  assign ctrl_raw = {id_funct7_5, id_funct3};

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec          = '0;
    dec.valid    = id_valid;
    dec.pc       = id_pc;
    dec.rs1_data = id_rs1_data;
    dec.rs2_data = id_rs2_data;
    dec.imm      = id_imm;
    dec.rs1      = id_rs1;
    dec.rs2      = id_rs2;
    dec.rd       = id_rd;
    dec.funct3   = id_funct3;
    writes       = 1'b0;
    case (id_opcode)
      OPC_OP: begin
        writes = 1'b1;
        if (!ctrl_raw[3] || ctrl_raw == 4'b1000 || ctrl_raw == 4'b1101) dec.alu_control = ctrl_raw;
        else dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        writes = 1'b1;
        dec.d2_sel = D2_IMM;
        // Only shifts carry funct7_5 meaningfully; elsewhere it is an imm bit.
        dec.alu_control = (id_funct3 == 3'b101) ? ctrl_raw : {1'b0, id_funct3};
      end
      OPC_LOAD: begin
        writes      = 1'b1;
        dec.is_load = 1'b1;
        dec.d2_sel  = D2_IMM;
      end
      OPC_STORE: begin
        dec.is_store = 1'b1;
        dec.d2_sel   = D2_IMM;
      end
      OPC_LUI: begin
        writes     = 1'b1;
        dec.d1_sel = D1_ZERO;
        dec.d2_sel = D2_IMM;
      end
      OPC_AUIPC: begin
        writes     = 1'b1;
        dec.d1_sel = D1_PC;
        dec.d2_sel = D2_IMM;
      end
      OPC_JAL, OPC_JALR: begin
        writes     = 1'b1;
        dec.d1_sel = D1_PC;
        dec.d2_sel = D2_FOUR;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        case (id_funct3)
          3'b000, 3'b001: dec.alu_control = 4'b1000;
          3'b100, 3'b101: dec.alu_control = 4'b0010;
          3'b110, 3'b111: dec.alu_control = 4'b0011;
          default:        dec.illegal     = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = writes && !dec.illegal && (id_rd != 5'd0);
  end

  always_comb begin
    uses_rs1       = !(id_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    uses_rs2       = id_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    load_use_stall = !flush && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && id_valid &&
                     ((uses_rs1 && id_rs1 == ex_q.rd) || (uses_rs2 && id_rs2 == ex_q.rd));
  end

  always_comb begin
    ex_d = dec;
    if (flush || load_use_stall) ex_d = '0;
    if (stall && !flush)         ex_d = ex_q;
  end

  // NOTE: synchronous reset, and non-blocking assignment for all sequential state.
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf_data);
    if (rs != 5'd0 && exm_we && exm_rd == rs)      return exm_result;
    else if (rs != 5'd0 && mwb_we && mwb_rd == rs) return mwb_result;
    else                                           return rf_data;
  endfunction

  always_comb begin
    rs1_fwd = fwd(ex_q.rs1, ex_q.rs1_data);
    rs2_fwd = fwd(ex_q.rs2, ex_q.rs2_data);
    case (ex_q.d1_sel)
      D1_PC:   alu_d1 = ex_q.pc;
      D1_ZERO: alu_d1 = 32'd0;
      default: alu_d1 = rs1_fwd;
    endcase
    case (ex_q.d2_sel)
      D2_IMM:  alu_d2 = ex_q.imm;
      D2_FOUR: alu_d2 = 32'd4;
      default: alu_d2 = rs2_fwd;
    endcase
  end

  assign alu_control   = ex_q.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_is_load    = ex_q.is_load;
  assign ex_is_store   = ex_q.is_store;
  assign ex_is_branch  = ex_q.is_branch;
  assign ex_illegal    = ex_q.illegal;
  assign ex_rd         = ex_q.rd;
  assign ex_pc         = ex_q.pc;
  assign ex_funct3     = ex_q.funct3;
  assign ex_store_data = rs2_fwd;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

The ID/EX pipeline register and operand-select stage that sits directly upstream of the execute-stage `alu`. Each cycle it captures one decoded RV32I instruction and generates the 4-bit `alu` control code from opcode/funct3/funct7[5]. It selects the ALU operands, including EX/MEM and MEM/WB forwarding. It also detects load-use hazards so the decode stage can stall while this stage inserts a bubble.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, **synchronous and active-low**.
- `id_valid` in 1: decode presents a valid instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in 32 each: decode fields (register-file reads, sign-extended immediate).
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register addresses.
- `id_opcode` in 7, `id_funct3` in 3, `id_funct7_5` in 1: instruction fields.
- `stall` in 1: downstream hold.
- `flush` in 1: branch/jump redirect, kills the instruction in this stage.
- `exm_rd` in 5, `exm_we` in 1, `exm_result` in 32: EX/MEM write-back candidate.
- `mwb_rd` in 5, `mwb_we` in 1, `mwb_result` in 32: MEM/WB write-back candidate.
- `alu_d1`, `alu_d2` out 32: ALU operands.
- `alu_control` out 4: ALU operation.
- `ex_valid`, `ex_reg_write`, `ex_is_load`, `ex_is_store`, `ex_is_branch`, `ex_illegal` out 1 each: registered flags.
- `ex_rd` out 5, `ex_pc` out 32, `ex_store_data` out 32: rs2 after forwarding.
- `ex_funct3` out 3: passed to memory and branch logic.
- `load_use_stall` out 1: request to hold IF/ID.

## Operation
- Register update priority each cycle: `!rst_n` > `flush` > `stall` > `load_use_stall` > capture.
  - `flush`: `ex_valid` is set to 0.
  - `stall`: all registers hold.
  - `load_use_stall`: a bubble is inserted (`ex_valid` = 0; other fields are don't-care but are cleared).
  - capture: `id_*` are latched and `ex_valid` = `id_valid`.
- Forwarding is combinational from the *registered* rs1/rs2 addresses and data. It is applied separately to rs1 and rs2.
  - The EX/MEM source is chosen when `exm_we` is set, `exm_rd` != 0 and `exm_rd` matches the register.
  - Otherwise the MEM/WB source is chosen under the same rule using `mwb_*`.
  - Otherwise the register-file value is used.
  - x0 is never forwarded.
- Operand select and control by registered opcode:
  - OP (0110011): d1 = rs1, d2 = rs2, control = {funct7_5, funct3}.
  - OP-IMM (0010011): d1 = rs1, d2 = imm.
    - control = {funct7_5, funct3} when funct3 = 101.
    - control = {0, funct3} otherwise, so ADDI never becomes SUB.
  - LOAD (0000011) and STORE (0100011): d1 = rs1, d2 = imm, control = 0000 (ADD).
  - LUI (0110111): d1 = 0, d2 = imm, control = ADD.
  - AUIPC (0010111): d1 = pc, d2 = imm, control = ADD.
  - JAL (1101111) and JALR (1100111): d1 = pc, d2 = 4, control = ADD (link value).
  - BRANCH (1100011): d1 = rs1, d2 = rs2. control is:
    - funct3 000/001 → 1000 (SUB)
    - funct3 100/101 → 0010 (SLT)
    - funct3 110/111 → 0011 (SLTU)
    - other funct3 → illegal
  - Any other opcode, or OP with a control code outside {0000–0111, 1000, 1101}: `ex_illegal` = 1, `ex_reg_write` = 0, control = ADD.
- `ex_reg_write` = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR when `id_rd` != 0.
- `ex_store_data` = forwarded rs2, regardless of opcode.
- `load_use_stall` (combinational) is asserted when all of the following hold:
  - `ex_valid` and `ex_is_load` are set, and `ex_rd` != 0;
  - `id_valid` is set;
  - `id_rs1` == `ex_rd` and the decode opcode uses rs1, or `id_rs2` == `ex_rd` and the decode opcode uses rs2.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used by OP, STORE and BRANCH only.
- `load_use_stall` is forced to 0 while `flush` is set.

## Timing
- Reset value of every registered output is 0. Hence after reset `alu_d1` = `alu_d2` = 0 and `alu_control` = 0000.
- Latency: an `id_*` instruction captured at edge N appears on the `ex_*` and `alu_*` outputs after edge N, for exactly one cycle unless `stall` is set.
- Forwarded operands follow `exm_*`/`mwb_*` in the same cycle, with zero latency. This stays true while the stage is stalled.
- Reset, flush and stall that arrive mid-sequence take effect at the next edge with no residual state. Flush beats stall in the same cycle.
- `load_use_stall` lasts exactly one cycle per hazard: after the bubble edge, `ex_is_load` is 0.

## Test plan
1. **Reset:** assert `rst_n` = 0 for 2 cycles with `id_valid` = 1 → all outputs 0, `load_use_stall` = 0.
2. **Decode control:**
   - SUB x3,x1,x2 (funct7_5 = 1, funct3 = 000) → `alu_control` = 1000.
   - SRAI (OP-IMM, 101, funct7_5 = 1) → 1101.
   - ADDI with imm bit 10 set → 0000.
   - LUI imm 0x12345000 → d1 = 0, d2 = 0x12345000.
3. **Forwarding priority:** EX rs1 = x5 with `exm_rd` = 5 (0xAAAA) and `mwb_rd` = 5 (0xBBBB) → `alu_d1` = 0xAAAA. Then `exm_we` = 0 → 0xBBBB. Then with `rs1` = x0 → register-file value.
4. **Load-use:** LW x7 in EX, decode ADD x8,x7,x1 → `load_use_stall` = 1 for one cycle, bubble (`ex_valid` = 0), then ADD captured. Repeat with LUI x7 in decode → no stall.
5. **Flush vs stall:** `flush` = `stall` = 1 → `ex_valid` = 0 next cycle. Then `stall` only → all outputs hold for 3 cycles.
6. **Illegal:** opcode 1111111 → `ex_illegal` = 1, `ex_reg_write` = 0, `alu_control` = 0000.
